mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares the single main-memory port between the instruction-fetch miss path
// (I-side) and the data-memory miss/write path (D-side).
// Read misses become full line fills. One word address is issued per cycle to
// the pipelined memory. Returned words are streamed back to the side that owns
// the fill, tagged with their word index. D-side stores are single-word
// write-through accesses.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req, i_addr               I-side fill request (held until i_done) and byte address
//   d_req, d_we, d_addr,        D-side request (held until d_done);
//   d_wdata                     d_we=1 selects a single-word write
//   i_fill_valid, d_fill_valid  fill word valid for the owning side
//   fill_idx, fill_data         word index within the line and returned word
//   i_done, d_done              one-cycle completion pulses
//   busy                        arbiter is serving a request
//   mem_en, mem_wr, mem_addr,   memory access strobe, write qualifier, byte address,
//   mem_wdata                   write data
//   mem_rdata, mem_rvalid       in-order read return from memory

module mem_arbiter #(
    parameter  int LINE_WORDS = 8,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             i_fill_valid,
    output logic             d_fill_valid,
    output logic [IDX_W-1:0] fill_idx,
    output logic [15:0]      fill_data,
    output logic             i_done,
    output logic             d_done,
    output logic             busy,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_rvalid
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, WRITE} state_t;

    localparam logic [IDX_W:0] LAST_CNT  = (IDX_W + 1)'(LINE_WORDS - 1);
    // Clears the word-index bits and the byte-in-word bit to get the line base.
    localparam logic [15:0]    LINE_MASK = ~(16'(2 * LINE_WORDS) - 16'd1);

    state_t         state;
    state_t         state_next;
    logic           owner_d;
    logic           last_d;
    logic [IDX_W:0] issue_cnt;
    logic [IDX_W:0] ret_cnt;
    logic [15:0]    base_addr;
    logic [15:0]    wr_addr;
    logic [15:0]    wr_data;
    logic [15:0]    word_off;
    logic           grant_i;
    logic           grant_d;
    logic           ret_fire;
    logic           last_ret;
    logic           last_issue;

    // D wins by default. I wins only when D owned the previous grant, so a
    // stream of D writes cannot starve instruction fetch.
    // Returns are accepted only while a fill is in flight. Anything arriving
    // in IDLE, for example left over from before a reset, is dropped.
    always_comb begin
        grant_i    = i_req && (!d_req || last_d);
        grant_d    = d_req && !grant_i;
        ret_fire   = mem_rvalid && (state == ISSUE || state == DRAIN)
                     && (ret_cnt <= LAST_CNT);
        last_ret   = ret_fire && (ret_cnt == LAST_CNT);
        last_issue = (state == ISSUE) && (issue_cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The base address has its low bits clear, so OR-ing in the word offset
    // never carries out of the line.
    // When the memory answers in the same cycle as the last issue, the final
    // return happens while still in ISSUE, so DRAIN is skipped.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        word_off   = 16'(issue_cnt[IDX_W-1:0]) << 1;
        unique case (state)
            IDLE: begin
                if (grant_d && d_we) begin
                    state_next = WRITE;
                end else if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = base_addr | word_off;
                if (last_ret) begin
                    state_next = DONE;
                end else if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_ret) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                i_done     = !owner_d;
                d_done     = owner_d;
                state_next = IDLE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = wr_addr;
                mem_wdata  = wr_data;
                d_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured at grant time because requesters may change
    // them while busy.
    // Fill outputs are registered, so each word appears one cycle after its
    // mem_rvalid. The final word therefore coincides with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d      <= 1'b0;
            last_d       <= 1'b0;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            base_addr    <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            fill_idx     <= '0;
            fill_data    <= '0;
        end else begin
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            if (state == IDLE && (grant_i || grant_d)) begin
                owner_d   <= grant_d;
                last_d    <= grant_d;
                base_addr <= (grant_d ? d_addr : i_addr) & LINE_MASK;
                wr_addr   <= d_addr;
                wr_data   <= d_wdata;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
            if (state == ISSUE) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (ret_fire) begin
                ret_cnt      <= ret_cnt + 1'b1;
                fill_data    <= mem_rdata;
                fill_idx     <= ret_cnt[IDX_W-1:0];
                i_fill_valid <= !owner_d;
                d_fill_valid <= owner_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// --------------
// Drives mem_arbiter with I-side and D-side requesters and a pipelined memory
// of configurable latency.
// A transaction-level reference model decides the grant order and the
// expected memory accesses, fill words, done pulses and busy window.
// Expected events are queued with their cycle numbers. A monitor pops and
// compares them as the DUT presents each output.

module tb_mem_arbiter;

    localparam int LW         = 8;
    localparam int LINE_BYTES = 2 * LW;

    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
    typedef struct { int cyc; logic side; logic [2:0] idx; logic [15:0] data; } fill_exp_t;
    typedef struct { int cyc; logic side; } done_exp_t;
    typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; int gap; } txn_t;
    typedef struct { int due; logic [15:0] data; } rd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        busy;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 4;
    int free_cyc = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    logic model_last_d = 1'b0;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];
    done_exp_t exp_done[$];
    txn_t      i_txq[$];
    txn_t      d_txq[$];
    rd_t       rd_q[$];

    logic [15:0] ram     [32768];
    logic [15:0] ref_mem [32768];

    mem_arbiter #(.LINE_WORDS(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .i_fill_valid (i_fill_valid),
        .d_fill_valid (d_fill_valid),
        .fill_idx     (fill_idx),
        .fill_data    (fill_data),
        .i_done       (i_done),
        .d_done       (d_done),
        .busy         (busy),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    // Free-running clock; the DUT acts on rising edges and the bench on falling ones.
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queues one request for the I-side (side_d=0) or D-side (side_d=1) requester.
    task automatic apply_stimulus(input logic side_d, input logic [15:0] addr, input logic we,
                                  input logic [15:0] wdata, input int gap);
        txn_t t;
        t.addr  = addr;
        t.we    = we;
        t.wdata = wdata;
        t.gap   = gap;
        if (side_d) d_txq.push_back(t);
        else        i_txq.push_back(t);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},         32'(busy),         32'd0);
        check_output({tag, "_mem_en"},       32'(mem_en),       32'd0);
        check_output({tag, "_mem_wr"},       32'(mem_wr),       32'd0);
        check_output({tag, "_mem_addr"},     32'(mem_addr),     32'd0);
        check_output({tag, "_mem_wdata"},    32'(mem_wdata),    32'd0);
        check_output({tag, "_i_fill_valid"}, 32'(i_fill_valid), 32'd0);
        check_output({tag, "_d_fill_valid"}, 32'(d_fill_valid), 32'd0);
        check_output({tag, "_fill_idx"},     32'(fill_idx),     32'd0);
        check_output({tag, "_fill_data"},    32'(fill_data),    32'd0);
        check_output({tag, "_i_done"},       32'(i_done),       32'd0);
        check_output({tag, "_d_done"},       32'(d_done),       32'd0);
    endtask

    // Waits, with a cycle budget, until every request has been served and every
    // expected event consumed. An expired budget counts as a failure.
    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(i_txq.size() == 0 && d_txq.size() == 0 && !i_req && !d_req &&
               exp_mem.size() == 0 && exp_fill.size() == 0 && exp_done.size() == 0 &&
               rd_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("[TB] FAIL idle_timeout: got %0d cycles without draining, limit %0d", n, max_cyc);
        end
    endtask

    // Reference model for the grant a DUT in IDLE makes on the edge ending cycle c.
    // It lays out the whole transaction timeline from latency arithmetic.
    task automatic model_grant(input int c);
        logic gi;
        logic gd;
        int   a;
        int   base;
        gi = i_req && (!d_req || model_last_d);
        gd = d_req && !gi;
        if (gd && d_we) begin
            exp_mem.push_back('{c + 1, 1'b1, d_addr, d_wdata});
            exp_done.push_back('{c + 1, 1'b1});
            ref_mem[d_addr[15:1]] = d_wdata;
            busy_lo      = c + 1;
            busy_hi      = c + 1;
            free_cyc     = c + 2;
            model_last_d = 1'b1;
        end else if (gi || gd) begin
            a    = gd ? int'(d_addr) : int'(i_addr);
            base = a - (a % LINE_BYTES);
            for (int k = 0; k < LW; k++) begin
                exp_mem.push_back('{c + 1 + k, 1'b0, 16'(base + 2 * k), 16'h0000});
                exp_fill.push_back('{c + k + 2 + lat, gd, 3'(k), ref_mem[(base / 2) + k]});
            end
            exp_done.push_back('{c + LW + lat + 1, gd});
            busy_lo      = c + 1;
            busy_hi      = c + LW + lat + 1;
            free_cyc     = c + LW + lat + 2;
            model_last_d = gd;
        end
    endtask

    // The model runs on the same edges the DUT samples on. Reset wipes every
    // pending expectation and restores the I-side as last owner.
    initial begin
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_mem.delete();
                exp_fill.delete();
                exp_done.delete();
                model_last_d = 1'b0;
                busy_lo      = 1;
                busy_hi      = 0;
                free_cyc     = 0;
            end else if (cyc >= free_cyc) begin
                model_grant(cyc);
            end
            cyc++;
        end
    end

    // Pipelined memory: a read seen in cycle t answers in cycle t+lat. Writes
    // land immediately. Returns still pending across a reset are delivered anyway.
    initial begin
        rd_t r;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 32768; i++) ram[i] = init_word(i);
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r          = rd_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = r.data;
            end
            if (mem_en) begin
                if (mem_wr) ram[mem_addr[15:1]] = mem_wdata;
                else        rd_q.push_back('{cyc + lat, ram[mem_addr[15:1]]});
            end
        end
    end

    // I-side requester: holds i_req until i_done, then waits for the next
    // transaction's gap before raising it again.
    initial begin
        txn_t t;
        int   wait_n;
        i_req  = 1'b0;
        i_addr = '0;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_req  = 1'b0;
                wait_n = 0;
            end else begin
                if (i_req && i_done) i_req = 1'b0;
                if (!i_req && i_txq.size() > 0) begin
                    if (wait_n >= i_txq[0].gap) begin
                        t      = i_txq.pop_front();
                        i_req  = 1'b1;
                        i_addr = t.addr;
                        wait_n = 0;
                    end else begin
                        wait_n++;
                    end
                end
            end
        end
    end

    // D-side requester: same handshake as the I-side, and it also carries the
    // write flag and write data.
    initial begin
        txn_t t;
        int   wait_n;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        wait_n  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                d_req  = 1'b0;
                wait_n = 0;
            end else begin
                if (d_req && d_done) d_req = 1'b0;
                if (!d_req && d_txq.size() > 0) begin
                    if (wait_n >= d_txq[0].gap) begin
                        t       = d_txq.pop_front();
                        d_req   = 1'b1;
                        d_we    = t.we;
                        d_addr  = t.addr;
                        d_wdata = t.wdata;
                        wait_n  = 0;
                    end else begin
                        wait_n++;
                    end
                end
            end
        end
    end

    // Monitor: each falling edge, match the DUT's memory strobe, fill word and
    // done pulse against the event expected in this cycle. Also check that
    // busy follows the model's busy window.
    initial begin
        mem_exp_t  me;
        fill_exp_t fe;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (exp_mem.size() > 0 && exp_mem[0].cyc == cyc) begin
                me = exp_mem.pop_front();
                check_output("mem_en", 32'(mem_en), 32'd1);
                check_output("mem_wr", 32'(mem_wr), 32'(me.wr));
                check_output("mem_addr", 32'(mem_addr), 32'(me.addr));
                if (me.wr) check_output("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
            end else if (mem_en) begin
                check_output("spurious_mem_en", 32'(mem_en), 32'd0);
            end

            if (exp_fill.size() > 0 && exp_fill[0].cyc == cyc) begin
                fe = exp_fill.pop_front();
                check_output(fe.side ? "fill_valid_d" : "fill_valid_i",
                             32'(fe.side ? d_fill_valid : i_fill_valid), 32'd1);
                check_output(fe.side ? "other_fv_i" : "other_fv_d",
                             32'(fe.side ? i_fill_valid : d_fill_valid), 32'd0);
                check_output("fill_idx", 32'(fill_idx), 32'(fe.idx));
                check_output("fill_data", 32'(fill_data), 32'(fe.data));
            end else if (i_fill_valid || d_fill_valid) begin
                check_output("spurious_fill_valid", 32'(i_fill_valid | d_fill_valid), 32'd0);
            end

            if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
                de = exp_done.pop_front();
                check_output(de.side ? "done_d" : "done_i", 32'(de.side ? d_done : i_done), 32'd1);
                check_output(de.side ? "idle_i" : "idle_d", 32'(de.side ? i_done : d_done), 32'd0);
            end else if (i_done || d_done) begin
                check_output("spurious_done", 32'(i_done | d_done), 32'd0);
            end

            check_output("busy", 32'(busy), 32'(rst_n && cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then randomized traffic, then reset recovery.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] checking reset state");
        check_reset_outputs("por");

        // Both sides requesting out of reset: D first, then I. Then both again: D.
        $display("[TB] simultaneous requests from reset");
        apply_stimulus(1'b1, 16'h2468, 1'b0, 16'h0000, 0);
        apply_stimulus(1'b0, 16'h1357, 1'b0, 16'h0000, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(200);
        apply_stimulus(1'b1, 16'h5A50, 1'b0, 16'h0000, 0);
        apply_stimulus(1'b0, 16'h0FFE, 1'b0, 16'h0000, 0);
        wait_idle(200);

        $display("[TB] I fill at 0x1236, latency 4");
        apply_stimulus(1'b0, 16'h1236, 1'b0, 16'h0000, 0);
        wait_idle(200);

        $display("[TB] D write 0x4002 <= 0xBEEF");
        apply_stimulus(1'b1, 16'h4002, 1'b1, 16'hBEEF, 0);
        wait_idle(200);

        $display("[TB] back-to-back D writes with I held");
        apply_stimulus(1'b1, 16'h6010, 1'b1, 16'h1111, 0);
        apply_stimulus(1'b1, 16'h601E, 1'b1, 16'h2222, 0);
        apply_stimulus(1'b0, 16'h7770, 1'b0, 16'h0000, 0);
        wait_idle(300);
        apply_stimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 0);
        apply_stimulus(1'b0, 16'h6014, 1'b0, 16'h0000, 2);
        wait_idle(300);

        $display("[TB] randomized traffic");
        for (int b = 0; b < 4; b++) begin
            lat = int'($urandom_range(1, 5));
            for (int n = 0; n < 6; n++) begin
                apply_stimulus(1'b0, 16'($urandom), 1'b0, 16'h0000, int'($urandom_range(0, 4)));
                apply_stimulus(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                               int'($urandom_range(0, 4)));
            end
            wait_idle(3000);
        end

        $display("[TB] latency 1 fills");
        lat = 1;
        apply_stimulus(1'b0, 16'hABCD, 1'b0, 16'h0000, 0);
        apply_stimulus(1'b1, 16'h3332, 1'b0, 16'h0000, 3);
        wait_idle(300);

        // Reset during ISSUE with issue_cnt = 3; the first fill word is on the outputs.
        $display("[TB] reset mid-fill");
        lat = 2;
        apply_stimulus(1'b0, 16'h9ABC, 1'b0, 16'h0000, 0);
        wait (i_req);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (lat + 4) @(negedge clk);
        apply_stimulus(1'b0, 16'h9ABC, 1'b0, 16'h0000, 0);
        wait_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
